// File: rtl/tag_frame_assembler.sv
// tag_frame_assembler: packs decoded FM0 tag-reply bits into one frame word
// with an in-line EPC Gen2 CRC-16 check and a single-cycle result pulse.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   arm           - start-of-frame request, latches frame_len / crc_en
//   frame_len     - expected bit count, CRC included (1..MAX_BITS)
//   crc_en        - check CRC-16 residue for this frame
//   in_bit/in_vld - decoded bit and its qualifier, one bit per cycle max
//   out_data      - frame, right-aligned, first bit at [len-1]
//   out_len       - length of frame in out_data
//   out_vld       - one-cycle pulse, frame complete
//   out_crc_ok    - residue matched (or crc_en was 0), valid with out_vld
//   out_err       - one-cycle pulse, illegal arm or inter-bit timeout
//   busy          - collecting
//
// Option: define FRAME_TIMEOUT_EN to abort a frame after TIMEOUT idle
// clocks between accepted bits.

module tag_frame_assembler #(
  parameter int MAX_BITS  = 128,
  parameter int LEN_WIDTH = $clog2(MAX_BITS + 1),
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 crc_en,
  input  logic                 in_bit,
  input  logic                 in_vld,
  output logic [MAX_BITS-1:0]  out_data,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_vld,
  output logic                 out_crc_ok,
  output logic                 out_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  state_t               state_q, state_d;
  logic [MAX_BITS-1:0]  shreg_q, shreg_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 crc_en_q, crc_en_d;
  logic [15:0]          crc_q, crc_d;

  logic [MAX_BITS-1:0]  out_data_q, out_data_d;
  logic [LEN_WIDTH-1:0] out_len_q, out_len_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_crc_ok_q, out_crc_ok_d;
  logic                 out_err_q, out_err_d;
  logic                 busy_q, busy_d;

  logic                 len_ok;
  logic                 fb;
  logic [15:0]          crc_nxt;
  logic [MAX_BITS-1:0]  shreg_nxt;
  logic [LEN_WIDTH-1:0] cnt_nxt;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign len_ok = (frame_len != '0) &&
                  (frame_len <= LEN_WIDTH'(MAX_BITS));

  assign fb        = crc_q[15] ^ in_bit;
  assign crc_nxt   = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0);
  assign shreg_nxt = {shreg_q[MAX_BITS-2:0], in_bit};
  assign cnt_nxt   = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    crc_en_d     = crc_en_q;
    crc_d        = crc_q;
    out_data_d   = out_data_q;
    out_len_d    = out_len_q;
    out_crc_ok_d = out_crc_ok_q;
    out_vld_d    = 1'b0;
    out_err_d    = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    // arm outranks everything, including a bit arriving the same cycle
    if (arm) begin
      if (len_ok) begin
        state_d  = S_COLLECT;
        len_d    = frame_len;
        crc_en_d = crc_en;
        shreg_d  = '0;
        cnt_d    = '0;
        crc_d    = CRC_PRESET;
`ifdef FRAME_TIMEOUT_EN
        tmo_d    = '0;
`endif
      end else begin
        state_d   = S_IDLE;
        out_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_COLLECT: begin
          if (in_vld) begin
            shreg_d = shreg_nxt;
            cnt_d   = cnt_nxt;
            crc_d   = crc_nxt;
`ifdef FRAME_TIMEOUT_EN
            tmo_d   = '0;
`endif
            if (cnt_nxt == len_q) begin
              state_d      = S_DONE;
              out_vld_d    = 1'b1;
              out_data_d   = shreg_nxt;
              out_len_d    = len_q;
              out_crc_ok_d = !crc_en_q ||
                             (crc_nxt == CRC_RESIDUE);
            end
          end
`ifdef FRAME_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            out_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      crc_en_q     <= 1'b0;
      crc_q        <= CRC_PRESET;
      out_data_q   <= '0;
      out_len_q    <= '0;
      out_vld_q    <= 1'b0;
      out_crc_ok_q <= 1'b0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      crc_en_q     <= crc_en_d;
      crc_q        <= crc_d;
      out_data_q   <= out_data_d;
      out_len_q    <= out_len_d;
      out_vld_q    <= out_vld_d;
      out_crc_ok_q <= out_crc_ok_d;
      out_err_q    <= out_err_d;
      busy_q       <= busy_d;
`ifdef FRAME_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign out_data   = out_data_q;
  assign out_len    = out_len_q;
  assign out_vld    = out_vld_q;
  assign out_crc_ok = out_crc_ok_q;
  assign out_err    = out_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tag_frame_assembler.sv
// tb_tag_frame_assembler: directed bench for tag_frame_assembler.
// Inputs change 1ns after posedge; outputs are checked there too.

module tb_tag_frame_assembler;

  localparam int MB = 128;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [LW-1:0] frame_len;
  logic          crc_en;
  logic          in_bit;
  logic          in_vld;
  logic [MB-1:0] out_data;
  logic [LW-1:0] out_len;
  logic          out_vld;
  logic          out_crc_ok;
  logic          out_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;

  tag_frame_assembler #(
    .MAX_BITS (MB),
    .LEN_WIDTH(LW),
    .TIMEOUT  (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .frame_len (frame_len),
    .crc_en    (crc_en),
    .in_bit    (in_bit),
    .in_vld    (in_vld),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_vld   (out_vld),
    .out_crc_ok(out_crc_ok),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_vld) vld_cnt++;
    if (out_err) err_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [MB-1:0] obs,
                     input logic [MB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic b);
    in_bit = b;
    in_vld = 1'b1;
    cyc();
    in_vld = 1'b0;
    in_bit = 1'b0;
  endtask

  task automatic do_arm(input logic [LW-1:0] l, input logic c);
    frame_len = l;
    crc_en    = c;
    arm       = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  function automatic logic [MB-1:0] mk_crc_frame(input logic [MB-1:0] d);
    logic [MB-1:0] f;
    logic [15:0]   c;
    logic          fb;
    f = d;
    c = 16'hFFFF;
    for (int i = MB - 1; i >= 16; i--) begin
      fb = c[15] ^ f[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    f[15:0] = ~c;
    return f;
  endfunction

  logic [15:0]   rn16;
  logic [MB-1:0] frame;
  logic [MB-1:0] bad;
  logic [7:0]    b8;
  int            v0;
  int            e0;

  initial begin
    rst       = 1'b1;
    arm       = 1'b0;
    frame_len = '0;
    crc_en    = 1'b0;
    in_bit    = 1'b0;
    in_vld    = 1'b0;
    #3;
    chk("rst_data", out_data, '0);
    chk("rst_len", MB'(out_len), '0);
    chk("rst_vld", MB'(out_vld), '0);
    chk("rst_crc_ok", MB'(out_crc_ok), '0);
    chk("rst_err", MB'(out_err), '0);
    chk("rst_busy", MB'(busy), '0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // RN16, no CRC, one bit per 4 clocks
    rn16 = 16'hA5C3;
    v0   = vld_cnt;
    do_arm(8'd16, 1'b0);
    chk("rn16_busy_armed", MB'(busy), 1);
    for (int i = 15; i >= 0; i--) begin
      put(rn16[i]);
      if (i == 1) begin
        chk("rn16_no_early_vld", MB'(out_vld), 0);
        chk("rn16_busy_mid", MB'(busy), 1);
      end
      if (i > 0) repeat (3) cyc();
    end
    chk("rn16_vld", MB'(out_vld), 1);
    chk("rn16_data", out_data, MB'(16'hA5C3));
    chk("rn16_len", MB'(out_len), 16);
    chk("rn16_crc_ok", MB'(out_crc_ok), 1);
    chk("rn16_busy_done", MB'(busy), 0);
    cyc();
    chk("rn16_vld_pulse", MB'(out_vld), 0);
    chk("rn16_hold_data", out_data, MB'(16'hA5C3));
    chk("rn16_vld_count", MB'(vld_cnt - v0), 1);

    // 128-bit CRC frame, good then with bit 5 flipped
    frame[127:96] = $urandom();
    frame[95:64]  = $urandom();
    frame[63:32]  = $urandom();
    frame[31:0]   = $urandom();
    frame = mk_crc_frame(frame);
    do_arm(8'd128, 1'b1);
    for (int i = MB - 1; i >= 0; i--) put(frame[i]);
    chk("crc_good_vld", MB'(out_vld), 1);
    chk("crc_good_data", out_data, frame);
    chk("crc_good_len", MB'(out_len), 128);
    chk("crc_good_ok", MB'(out_crc_ok), 1);
    cyc();

    bad    = frame;
    bad[5] = ~bad[5];
    do_arm(8'd128, 1'b1);
    for (int i = MB - 1; i >= 0; i--) put(bad[i]);
    chk("crc_bad_vld", MB'(out_vld), 1);
    chk("crc_bad_data", out_data, bad);
    chk("crc_bad_ok", MB'(out_crc_ok), 0);
    cyc();

    // illegal arms
    v0 = vld_cnt;
    e0 = err_cnt;
    do_arm(8'd0, 1'b0);
    chk("ill0_err", MB'(out_err), 1);
    chk("ill0_busy", MB'(busy), 0);
    cyc();
    chk("ill0_err_pulse", MB'(out_err), 0);
    do_arm(8'd129, 1'b0);
    chk("ill129_err", MB'(out_err), 1);
    chk("ill129_busy", MB'(busy), 0);
    cyc();
    chk("ill_err_count", MB'(err_cnt - e0), 2);
    chk("ill_no_vld", MB'(vld_cnt - v0), 0);
    chk("ill_busy_after", MB'(busy), 0);

    // re-arm mid-frame, with a bit presented on the re-arm cycle
    v0 = vld_cnt;
    e0 = err_cnt;
    do_arm(8'd32, 1'b0);
    for (int i = 0; i < 10; i++) put(1'b1);
    frame_len = 8'd8;
    crc_en    = 1'b0;
    arm       = 1'b1;
    in_bit    = 1'b1;
    in_vld    = 1'b1;
    cyc();
    arm    = 1'b0;
    in_vld = 1'b0;
    chk("rearm_busy", MB'(busy), 1);
    chk("rearm_no_vld", MB'(vld_cnt - v0), 0);
    b8 = 8'h3C;
    for (int i = 7; i >= 0; i--) put(b8[i]);
    chk("rearm_vld", MB'(out_vld), 1);
    chk("rearm_data", out_data, MB'(8'h3C));
    chk("rearm_len", MB'(out_len), 8);
    chk("rearm_crc_ok", MB'(out_crc_ok), 1);
    cyc();
    chk("rearm_vld_count", MB'(vld_cnt - v0), 1);
    chk("rearm_err_count", MB'(err_cnt - e0), 0);

    // asynchronous reset mid-frame
    v0 = vld_cnt;
    do_arm(8'd16, 1'b1);
    for (int i = 0; i < 7; i++) put(1'b1);
    rst = 1'b1;
    #1;
    chk("arst_data", out_data, '0);
    chk("arst_len", MB'(out_len), 0);
    chk("arst_busy", MB'(busy), 0);
    #1;
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 9; i++) put(1'b1);
    cyc();
    chk("arst_no_vld", MB'(vld_cnt - v0), 0);
    chk("arst_data_after", out_data, '0);
    chk("arst_len_after", MB'(out_len), 0);
    chk("arst_crc_ok_after", MB'(out_crc_ok), 0);
    chk("arst_err_after", MB'(out_err), 0);
    chk("arst_busy_after", MB'(busy), 0);

    // inter-bit timeout behaviour
    v0 = vld_cnt;
    e0 = err_cnt;
    do_arm(8'd16, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b1);
`ifdef FRAME_TIMEOUT_EN
    repeat (19) cyc();
    chk("tmo_not_yet", MB'(err_cnt - e0), 0);
    chk("tmo_busy_before", MB'(busy), 1);
    cyc();
    chk("tmo_err", MB'(out_err), 1);
    chk("tmo_busy", MB'(busy), 0);
    cyc();
    chk("tmo_err_count", MB'(err_cnt - e0), 1);
    chk("tmo_no_vld", MB'(vld_cnt - v0), 0);
`else
    repeat (40) cyc();
    chk("notmo_busy", MB'(busy), 1);
    chk("notmo_no_err", MB'(err_cnt - e0), 0);
    chk("notmo_no_vld", MB'(vld_cnt - v0), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
